// File: rtl/flip_flop_fifo_with_counter.sv
// Flip-flop FIFO. An occupancy counter tells full from empty
// when the read and write pointers are equal.
module flip_flop_fifo_with_counter #(
    parameter int entry_width = 8,
    parameter int depth       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [entry_width-1:0] i_data,
    output logic [entry_width-1:0] o_data,
    output logic                   o_empty,
    output logic                   o_full
);
    localparam int AW = $clog2(depth);

    logic [entry_width-1:0] r_mem [depth];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    always_comb begin
        o_empty   = (r_count == '0);
        o_full    = (r_count == (AW+1)'(depth));
        w_do_pop  = i_pop & ~o_empty;
        // A full FIFO still accepts a push when it is popped in the same cycle
        w_do_push = i_push & (~o_full | w_do_pop);
        o_data    = r_mem[r_rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/frame_stats_fifo.sv
// Per-frame word count, saturating sum and maximum,
// queued into a small result FIFO with a sticky drop flag.
module frame_stats_fifo #(
    parameter int width     = 8,
    parameter int len_width = 8,
    parameter int depth     = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       up_valid,
    input  logic                       up_last,
    input  logic [width-1:0]           up_data,
    output logic                       down_valid,
    input  logic                       down_ready,
    output logic [len_width-1:0]       down_len,
    output logic [width+len_width-1:0] down_sum,
    output logic [width-1:0]           down_max,
    output logic                       overflow
);
    localparam int SW = width + len_width;

    typedef struct packed {
        logic [len_width-1:0] len;
        logic [SW-1:0]        sum;
        logic [width-1:0]     max;
    } entry_t;

    logic [len_width-1:0] r_cnt;
    logic [SW-1:0]        r_sum;
    logic [width-1:0]     r_max;
    logic                 r_overflow;

    logic [len_width-1:0] w_cnt_inc;
    logic [SW:0]          w_sum_ext;
    logic [SW-1:0]        w_sum_new;
    logic [width-1:0]     w_max_new;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    entry_t               w_entry;
    entry_t               w_head;

    always_comb begin
        w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        // One spare bit catches the carry so the sum clamps instead of wrapping
        w_sum_ext = {1'b0, r_sum} + (SW+1)'(up_data);
        w_sum_new = w_sum_ext[SW] ? '1 : w_sum_ext[SW-1:0];
        w_max_new = (up_data > r_max) ? up_data : r_max;
        w_entry   = '{len: w_cnt_inc, sum: w_sum_new, max: w_max_new};
        w_push    = up_valid & up_last;
        w_pop     = down_ready & ~w_empty;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_sum      <= '0;
            r_max      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (up_valid) begin
                if (up_last) begin
                    r_cnt <= '0;
                    r_sum <= '0;
                    r_max <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                    r_sum <= w_sum_new;
                    r_max <= w_max_new;
                end
            end
            if (w_push & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    flip_flop_fifo_with_counter #(
        .entry_width($bits(entry_t)),
        .depth      (depth)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (w_entry),
        .o_data (w_head),
        .o_empty(w_empty),
        .o_full (w_full)
    );

    always_comb begin
        down_valid = ~w_empty;
        down_len   = w_empty ? '0 : w_head.len;
        down_sum   = w_empty ? '0 : w_head.sum;
        down_max   = w_empty ? '0 : w_head.max;
        overflow   = r_overflow;
    end
endmodule

// File: tb/tb_frame_stats_fifo.sv
// Directed scoreboard bench for frame_stats_fifo, plus a
// narrow-length instance for count saturation.
module tb_frame_stats_fifo;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        up_valid = 1'b0;
    logic        up_last = 1'b0;
    logic [7:0]  up_data = '0;
    logic        down_ready = 1'b0;
    logic        down_valid;
    logic [7:0]  down_len;
    logic [15:0] down_sum;
    logic [7:0]  down_max;
    logic        overflow;

    logic        b_valid_in = 1'b0;
    logic        b_last = 1'b0;
    logic [7:0]  b_data = '0;
    logic        b_valid;
    logic [1:0]  b_len;
    logic [9:0]  b_sum;
    logic [7:0]  b_max;
    logic        b_ovf;

    typedef struct {
        int len;
        int sum;
        int max;
    } ent_t;

    ent_t q[$];
    ent_t pend;
    bit   have_push = 0;
    bit   exp_ovf = 0;
    int   mcnt = 0;
    int   msum = 0;
    int   mmax = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    frame_stats_fifo #(.width(8), .len_width(8), .depth(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .up_valid  (up_valid),
        .up_last   (up_last),
        .up_data   (up_data),
        .down_valid(down_valid),
        .down_ready(down_ready),
        .down_len  (down_len),
        .down_sum  (down_sum),
        .down_max  (down_max),
        .overflow  (overflow)
    );

    frame_stats_fifo #(.width(8), .len_width(2), .depth(DEPTH)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .up_valid  (b_valid_in),
        .up_last   (b_last),
        .up_data   (b_data),
        .down_valid(b_valid),
        .down_ready(1'b1),
        .down_len  (b_len),
        .down_sum  (b_sum),
        .down_max  (b_max),
        .overflow  (b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        bit pop;
        bit accept;
        pop = down_ready && (q.size() > 0);
        chk("valid", {31'd0, down_valid}, {31'd0, q.size() > 0});
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        if (q.size() > 0) begin
            chk("len", {24'd0, down_len}, q[0].len);
            chk("sum", {16'd0, down_sum}, q[0].sum);
            chk("max", {24'd0, down_max}, q[0].max);
        end else begin
            chk("len_idle", {24'd0, down_len}, 0);
            chk("sum_idle", {16'd0, down_sum}, 0);
            chk("max_idle", {24'd0, down_max}, 0);
        end
        accept = (q.size() < DEPTH) || pop;
        if (pop) void'(q.pop_front());
        if (have_push) begin
            if (accept) q.push_back(pend);
            else exp_ovf = 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic word(input logic [7:0] d, input logic l);
        int ncnt;
        int nsum;
        int nmax;
        up_valid = 1'b1;
        up_data  = d;
        up_last  = l;
        ncnt = (mcnt == 255) ? 255 : mcnt + 1;
        nsum = (msum + d > 65535) ? 65535 : msum + d;
        nmax = (d > mmax) ? d : mmax;
        if (l) begin
            pend = '{ncnt, nsum, nmax};
            have_push = 1;
            mcnt = 0;
            msum = 0;
            mmax = 0;
        end else begin
            mcnt = ncnt;
            msum = nsum;
            mmax = nmax;
        end
        step();
        up_valid  = 1'b0;
        up_last   = 1'b0;
        have_push = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        up_valid = 1'b1;
        up_data  = 8'd9;
        up_last  = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        up_valid = 1'b0;
        up_last  = 1'b0;
        q.delete();
        exp_ovf = 0;
        mcnt = 0;
        msum = 0;
        mmax = 0;
    endtask

    initial begin
        do_reset();
        step();

        // Three-word frame, then single 0xFF frame
        down_ready = 1'b1;
        word(8'd3, 1'b0);
        word(8'd5, 1'b0);
        word(8'd2, 1'b1);
        chk("f1_len_const", {24'd0, down_len}, 3);
        chk("f1_sum_const", {16'd0, down_sum}, 10);
        step();
        step();
        word(8'hFF, 1'b1);
        chk("ff_sum_const", {16'd0, down_sum}, 255);
        step();
        step();

        // Five frames into a depth-4 FIFO with no consumer
        down_ready = 1'b0;
        for (int k = 1; k <= 5; k++) word(8'(k), 1'b1);
        step();
        chk("ovf_const", {31'd0, overflow}, 1);
        down_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();

        // Full FIFO, last word coincides with a pop
        do_reset();
        down_ready = 1'b0;
        for (int k = 10; k <= 13; k++) word(8'(k), 1'b1);
        down_ready = 1'b1;
        word(8'd14, 1'b1);
        for (int k = 0; k < 5; k++) step();

        // Push and pop together on a partly filled FIFO
        down_ready = 1'b0;
        word(8'd1, 1'b1);
        down_ready = 1'b1;
        word(8'd2, 1'b1);
        word(8'd4, 1'b0);
        word(8'd9, 1'b0);
        word(8'd6, 1'b1);
        for (int k = 0; k < 3; k++) step();

        // Reset in the middle of a frame
        word(8'd7, 1'b0);
        word(8'd7, 1'b0);
        do_reset();
        step();
        word(8'd1, 1'b1);
        chk("rst_sum_const", {16'd0, down_sum}, 1);
        step();
        step();

        // Count and sum saturation on the wide instance
        for (int k = 0; k < 299; k++) word(8'hFF, 1'b0);
        word(8'hFF, 1'b1);
        chk("sat_len_const", {24'd0, down_len}, 255);
        chk("sat_sum_const", {16'd0, down_sum}, 65535);
        step();
        step();

        // Count saturation on the 2-bit length instance
        for (int k = 0; k < 6; k++) begin
            b_valid_in = 1'b1;
            b_data     = 8'h80;
            b_last     = (k == 5);
            @(posedge clock);
            #1;
        end
        b_valid_in = 1'b0;
        b_last     = 1'b0;
        chk("b_valid", {31'd0, b_valid}, 1);
        chk("b_len", {30'd0, b_len}, 3);
        chk("b_sum", {22'd0, b_sum}, 768);
        chk("b_max", {24'd0, b_max}, 8'h80);
        chk("b_ovf", {31'd0, b_ovf}, 0);
        @(posedge clock);
        #1;
        chk("b_drain", {31'd0, b_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/frame_stats_fifo.md
FRAME_STATS_FIFO -- requirements
Module: frame_stats_fifo

Interface
REQ-001 Parameter width, 8, data word width in bits.
REQ-002 Parameter len_width, 8, frame-length field width in bits.
REQ-003 Parameter depth, 4, result FIFO entries; power of two, >= 2.
REQ-004 clock  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 up_valid  input  1  word present this cycle; no ready, upstream never stalls.
REQ-007 up_last  input  1  qualified by up_valid; marks final word of a frame.
REQ-008 up_data  input  width  word payload, qualified by up_valid.
REQ-009 down_valid  output  1  result entry available.
REQ-010 down_ready  input  1  consumer accepts the entry when down_valid is also high.
REQ-011 down_len  output  len_width  word count of the frame.
REQ-012 down_sum  output  width+len_width  unsigned sum of the frame's words.
REQ-013 down_max  output  width  unsigned maximum word of the frame.
REQ-014 overflow  output  1  sticky: at least one frame result was dropped.

Function
REQ-015 Accumulators: cnt, sum and max, updated on every cycle with up_valid high; idle when up_valid is low.
REQ-016 Word with up_valid & !up_last: cnt += 1, sum += up_data, max = max(max, up_data).
REQ-017 Word with up_valid & up_last: push {cnt+1, sum+up_data, max(max,up_data)} into FIFO; clear cnt, sum and max to 0 in the same cycle.
REQ-018 Single-word frame (last word with cnt==0): push {1, up_data, up_data}.
REQ-019 cnt saturates at 2^len_width-1; further words still add to sum and update max; sum saturates at all-ones and never wraps.
REQ-020 Latency: result of a frame ending in cycle N is visible on down_* in cycle N+1 when the FIFO was empty.
REQ-021 FIFO is first-in first-out; pop on down_valid & down_ready.
REQ-022 down_valid = FIFO not empty; down_len/sum/max = head entry; held stable while down_valid & !down_ready.
REQ-023 Push while full without a pop in the same cycle: result dropped, FIFO unchanged, overflow set to 1.
REQ-024 Push while full with a pop in the same cycle: both occur; count unchanged; no overflow.
REQ-025 Push and pop on a non-full, non-empty FIFO in the same cycle: count unchanged, order preserved.
REQ-026 Pointers wrap modulo depth; full/empty are distinguished by an occupancy counter of log2(depth)+1 bits.
REQ-027 down_* outputs are 0 when down_valid is low.

Reset
REQ-028 Reset clears cnt, sum, max, FIFO pointers and occupancy, and overflow; down_valid=0 in the cycle after reset is sampled.
REQ-029 Reset mid-frame discards the partial frame; words before reset never contribute to any result.
REQ-030 Inputs sampled while reset is high are ignored.

Structure
REQ-031 No shared package; the result entry is a local packed struct {len, sum, max}.
REQ-032 The FIFO is a separate sub-module, flip_flop_fifo_with_counter, parameterised by entry width and depth; frame_stats_fifo instantiates it once.

Verification
REQ-033 Frame 3,5,2 (last on 2), down_ready=1 -> next cycle down_valid=1, len=3, sum=10, max=5, for exactly one cycle.
REQ-034 Single word 0xFF with last -> len=1, sum=255, max=255.
REQ-035 down_ready=0, five one-word frames 1..5, depth=4 -> entries 1..4 retained, overflow=1; with down_ready=1, results pop as 1,2,3,4.
REQ-036 FIFO full, last word arrives together with a pop -> no overflow; the new result appears after the three older entries.
REQ-037 Reset asserted after words 7,7 of an unfinished frame, then frame 1(last) -> len=1, sum=1, max=1.
REQ-038 len_width=2, frame of 6 words of 0x80 -> len=3 (saturated), sum=768, max=0x80.
